// File: rtl/parity_pkg.sv
// Shared encodings and the expected-parity rule for the UART parity generator/checker.
package parity_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        PAR  = 2'b10
    } rx_state_e;

    // xor_val is the XOR of all data bits; a disabled parity bit reads as 0.
    function automatic logic exp_parity(input par_mode_e mode, input logic xor_val,
                                        input logic par_en);
        logic p;
        p = 1'b0;
        if (par_en) begin
            case (mode)
                PAR_EVEN: p = xor_val;
                PAR_ODD:  p = ~xor_val;
                PAR_MARK: p = 1'b1;
                default:  p = 1'b0;
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational parity for a parallel word: XOR reduction followed by the mode mux.
module parity_tree
    import parity_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  par_mode_e        mode,
    input  logic             par_en,
    output logic             parity
);

    assign parity = exp_parity(mode, ^data, par_en);

endmodule

// File: rtl/parity_gen_chk.sv
// UART parity generator (parallel TX load) and serial RX parity checker with error statistics.
// Build option PARITY_STATS_EN: when defined, err_cnt is a saturating error counter; otherwise it is tied to 0.
module parity_gen_chk
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 par_en,
    input  logic                 load_bit,
    input  logic [WIDTH-1:0]     data,
    output logic                 p_out,
    output logic                 p_valid,
    input  logic                 frame_start,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic                 chk_done,
    output logic                 par_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // ---------------- TX path ----------------
    logic tx_parity;
    logic p_out_d, p_out_q, p_valid_d, p_valid_q;

    parity_tree #(.WIDTH(WIDTH)) u_tree (
        .data   (data),
        .mode   (par_mode_e'(mode)),
        .par_en (par_en),
        .parity (tx_parity)
    );

    always_comb begin
        p_out_d   = load_bit ? tx_parity : p_out_q;
        p_valid_d = load_bit;
    end

    // ---------------- RX path ----------------
    rx_state_e        state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    par_mode_e        mode_lat_q, mode_lat_d;
    logic             par_en_lat_q, par_en_lat_d;
    logic             chk_done_d, chk_done_q, par_err_d, par_err_q;
    logic             sticky_d, sticky_q;
    logic             last_bit;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next state and frame datapath; frame_start always wins over bit_valid.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mode_lat_d   = mode_lat_q;
        par_en_lat_d = par_en_lat_q;
        if (frame_start) begin
            state_d      = DATA;
            acc_d        = 1'b0;
            cnt_d        = '0;
            mode_lat_d   = par_mode_e'(mode);
            par_en_lat_d = par_en;
        end else if (bit_valid) begin
            case (state_q)
                DATA: begin
                    acc_d = acc_q ^ bit_in;
                    cnt_d = cnt_q + 1'b1;
                    if (last_bit) state_d = par_en_lat_q ? PAR : IDLE;
                end
                PAR:     state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Frame result, registered so it appears the cycle after the closing bit.
    always_comb begin
        chk_done_d = 1'b0;
        par_err_d  = 1'b0;
        if (!frame_start && bit_valid) begin
            if (state_q == DATA && last_bit && !par_en_lat_q) begin
                chk_done_d = 1'b1;
            end else if (state_q == PAR) begin
                chk_done_d = 1'b1;
                par_err_d  = (bit_in != exp_parity(mode_lat_q, acc_q, 1'b1));
            end
        end
    end

    // err_clr acts first so a coinciding error is still recorded.
    always_comb begin
        sticky_d = err_clr ? 1'b0 : sticky_q;
        if (par_err_d) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_out_q      <= 1'b0;
            p_valid_q    <= 1'b0;
            state_q      <= IDLE;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            mode_lat_q   <= PAR_EVEN;
            par_en_lat_q <= 1'b0;
            chk_done_q   <= 1'b0;
            par_err_q    <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            p_out_q      <= p_out_d;
            p_valid_q    <= p_valid_d;
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mode_lat_q   <= mode_lat_d;
            par_en_lat_q <= par_en_lat_d;
            chk_done_q   <= chk_done_d;
            par_err_q    <= par_err_d;
            sticky_q     <= sticky_d;
        end
    end

`ifdef PARITY_STATS_EN
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    always_comb begin
        err_cnt_d = err_clr ? '0 : err_cnt_q;
        if (par_err_d && (err_cnt_d != {ERR_CNT_W{1'b1}})) err_cnt_d = err_cnt_d + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) err_cnt_q <= '0;
        else      err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign p_out      = p_out_q;
    assign p_valid    = p_valid_q;
    assign chk_done   = chk_done_q;
    assign par_err    = par_err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// Randomised self-checking bench for parity_gen_chk against a frame-level reference model.
module tb_parity_gen_chk;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, load_bit, par_en, frame_start, bit_valid, bit_in, err_clr;
    logic [1:0]    mode;
    logic [W-1:0]  data;
    logic          p_out, p_valid, chk_done, par_err, err_sticky;
    logic [CW-1:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic       exp_p = 1'b0, exp_pv = 1'b0, exp_sticky = 1'b0;
    int         exp_cnt = 0;
    logic       tx_rand = 1'b0;

    parity_gen_chk #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .par_en(par_en), .load_bit(load_bit),
        .data(data), .p_out(p_out), .p_valid(p_valid), .frame_start(frame_start),
        .bit_valid(bit_valid), .bit_in(bit_in), .chk_done(chk_done), .par_err(par_err),
        .err_sticky(err_sticky), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic ref_parity(input logic [W-1:0] d, input logic [1:0] m, input logic e);
        if (!e) return 1'b0;
        case (m)
            2'd0:    return logic'($countones(d) % 2);
            2'd1:    return logic'(1 - ($countones(d) % 2));
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_error(input logic bad, input logic clr);
        if (clr) begin
            exp_sticky = 1'b0;
            exp_cnt    = 0;
        end
        if (bad) begin
            exp_sticky = 1'b1;
`ifdef PARITY_STATS_EN
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
`endif
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; the TX expectation is updated from the inputs present at the edge.
    task automatic step();
        if (tx_rand) begin
            load_bit = 1'($urandom_range(0, 1));
            data     = W'($urandom);
        end
        if (!rst) begin
            exp_p  = 1'b0;
            exp_pv = 1'b0;
        end else begin
            exp_pv = load_bit;
            if (load_bit) exp_p = ref_parity(data, mode, par_en);
        end
        @(posedge clk);
        #1;
        check("p_out", 32'(p_out), 32'(exp_p));
        check("p_valid", 32'(p_valid), 32'(exp_pv));
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_sticky"}, 32'(err_sticky), 32'(exp_sticky));
        check({tag, "_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_done"}, 32'(chk_done), 32'd0);
        check({tag, "_perr"}, 32'(par_err), 32'd0);
    endtask

    task automatic tx_load(input logic [W-1:0] d, input logic [1:0] m, input logic e);
        data = d; mode = m; par_en = e; load_bit = 1'b1;
        step();
        load_bit = 1'b0;
        step();
    endtask

    // Full frame: start, WIDTH data bits LSB first (random gaps), optional parity bit.
    task automatic send_frame(input logic [W-1:0] d, input logic [1:0] m, input logic e,
                              input logic bad, input logic clr_at_par);
        frame_start = 1'b1; mode = m; par_en = e;
        bit_valid = 1'($urandom_range(0, 1)); bit_in = 1'($urandom);
        step();
        idle_check("start");
        frame_start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bit_valid = 1'b0;
                step();
                idle_check("gap");
            end
            bit_valid = 1'b1; bit_in = d[i];
            mode = 2'($urandom); par_en = 1'($urandom);
            step();
            if (i == W - 1 && !e) begin
                check("nopar_done", 32'(chk_done), 32'd1);
                check("nopar_perr", 32'(par_err), 32'd0);
            end else begin
                idle_check("data");
            end
        end
        if (e) begin
            bit_valid = 1'b1;
            bit_in    = ref_parity(d, m, 1'b1) ^ bad;
            err_clr   = clr_at_par;
            model_error(bad, clr_at_par);
            step();
            check("par_done", 32'(chk_done), 32'd1);
            check("par_err", 32'(par_err), 32'(bad));
            check_stats("par");
            err_clr = 1'b0;
        end
        bit_valid = 1'($urandom_range(0, 1)); bit_in = 1'($urandom);
        step();
        idle_check("after");
        check_stats("after");
        bit_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; load_bit = 1'b0; par_en = 1'b1; frame_start = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0; err_clr = 1'b0; mode = 2'd0; data = '0;

        step();
        step();
        idle_check("reset");
        check_stats("reset");
        rst = 1'b1;
        step();

        // TX directed: 0xE9 has five ones.
        for (int m = 0; m < 4; m++) tx_load(8'hE9, 2'(m), 1'b1);
        tx_load(8'hE9, 2'd0, 1'b0);
        tx_load(8'hE9, 2'd2, 1'b0);
        load_bit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = W'($urandom); mode = 2'($urandom); par_en = 1'($urandom);
            step();
        end
        load_bit = 1'b0;
        step();

        // RX good, bad, saturation.
        send_frame(8'hE9, 2'd0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hE9, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 255; i++) send_frame(W'($urandom), 2'($urandom), 1'b1, 1'b1, 1'b0);

        // err_clr alone, and coincident with an error.
        err_clr = 1'b1;
        model_error(1'b0, 1'b1);
        step();
        err_clr = 1'b0;
        check_stats("clr");
        send_frame(8'h3C, 2'd1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h3C, 2'd1, 1'b1, 1'b1, 1'b1);

        // Restart after 4 bits, then a complete good frame.
        frame_start = 1'b1; mode = 2'd0; par_en = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; bit_in = 1'($urandom);
            step();
            idle_check("partial");
        end
        send_frame(8'hE9, 2'd0, 1'b1, 1'b0, 1'b0);

        // No-parity frame followed by stray bits in IDLE.
        send_frame(8'hE9, 2'd0, 1'b0, 1'b0, 1'b0);
        bit_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'($urandom);
            step();
            idle_check("idle_bit");
        end
        bit_valid = 1'b0;

        // Random frames with concurrent random TX activity.
        tx_rand = 1'b1;
        for (int i = 0; i < 60; i++)
            send_frame(W'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0));

        // Reset mid-frame aborts it silently.
        frame_start = 1'b1; mode = 2'd1; par_en = 1'b1;
        step();
        frame_start = 1'b0;
        bit_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bit_in = 1'($urandom);
            step();
        end
        rst = 1'b0;
        model_error(1'b0, 1'b1);
        step();
        step();
        idle_check("rst_mid");
        check_stats("rst_mid");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'($urandom);
            step();
            idle_check("post_rst");
        end
        bit_valid = 1'b0;
        tx_rand = 1'b0;
        load_bit = 1'b0;
        send_frame(8'hE9, 2'd0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 2'd3, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parity_gen_chk.md
Name: parity_gen_chk

Overview:
- Parametrised successor to the UART transmitter parity generator.
- TX side: a parallel-load path registers the parity bit for a WIDTH-bit word, with four selectable parity modes.
- RX side: a serial checker accumulates parity bit-by-bit over a frame, compares it with the received parity bit, and reports errors with sticky and counted status.
- Sits between the UART shift registers and the frame FSMs in both the transmitter and the receiver.

Parameters:
- WIDTH, 8, data bits per frame (legal 5..9).
- ERR_CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset.
- mode  in  2  parity mode: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
- par_en  in  1  parity enabled; 0 = no parity bit in the frame.
- load_bit  in  1  TX parallel load strobe.
- data  in  WIDTH  TX data word.
- p_out  out  1  registered TX parity bit.
- p_valid  out  1  one-cycle pulse: p_out was updated.
- frame_start  in  1  RX frame start; clears the accumulator.
- bit_valid  in  1  RX serial bit strobe.
- bit_in  in  1  RX serial bit, LSB first.
- chk_done  out  1  one-cycle pulse: frame check finished.
- par_err  out  1  one-cycle pulse coincident with chk_done on mismatch.
- err_sticky  out  1  set on any par_err; held until err_clr.
- err_cnt  out  ERR_CNT_W  saturating count of par_err events.
- err_clr  in  1  clears err_sticky and err_cnt.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, FSM to IDLE, accumulator 0, bit counter 0. Reset overrides every other input and aborts a frame in progress with no chk_done.
- TX parity value: XOR-reduce(data) for even; its inverse for odd; 1 for mark; 0 for space; 0 when par_en=0.
- TX timing: on a clk edge with load_bit=1, p_out takes the parity value computed from the current data/mode/par_en, and p_valid=1 for exactly one cycle. p_out holds between loads. Back-to-back loads update every cycle, with p_valid held high.
- RX: mode and par_en are latched at frame_start and ignored mid-frame.
- RX FSM:
  - IDLE: frame_start -> DATA; acc=0, cnt=0.
  - DATA: each bit_valid does acc ^= bit_in, cnt++. On the WIDTH-th bit: if the latched par_en=1 -> PAR; else -> IDLE with chk_done=1, par_err=0 on the following cycle.
  - PAR: bit_valid compares bit_in with the expected bit (acc for even, ~acc for odd, 1 for mark, 0 for space). Next state IDLE; chk_done=1 on the next cycle; par_err=1 on that same cycle if they differ.
- bit_valid in IDLE is ignored.
- frame_start in DATA or PAR restarts the frame (acc=0, cnt=0, state DATA) with no chk_done. If frame_start and bit_valid occur together, frame_start wins and the bit is dropped.
- Error statistics:
  - par_err sets err_sticky and increments err_cnt, saturating at all-ones.
  - err_clr applies before a same-cycle par_err, so the result is sticky=1, cnt=1.
- TX and RX paths are fully independent and may be active in the same cycle.

Optional Feature:
- Macro: PARITY_STATS_EN.
- Defined: err_cnt counter implemented as above.
- Undefined: counter not synthesised and err_cnt tied to 0. err_sticky and par_err are unaffected and the port list is unchanged.

Decomposition:
- Package parity_pkg holds:
  - mode encodings PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE;
  - RX state encoding IDLE/DATA/PAR;
  - a function computing expected parity from (mode, xor_val, par_en).
- One combinational sub-module, parity_tree: WIDTH-bit XOR reduction plus mode mux, used by the TX path. The RX path reuses the package function on acc.

Test Plan:
- Reset: rst=0 for 2 cycles mid-frame -> all outputs 0; no chk_done after release; next frame checks correctly.
- TX modes: data=8'hE9 (five ones), load_bit for 1 cycle.
  - Even -> p_out=1; odd -> 0; mark -> 1; space -> 0.
  - p_valid pulses once per load.
  - par_en=0 -> p_out=0.
- RX good frame: even mode, serial 1,0,0,1,0,1,1,1 (0xE9 LSB first), parity bit 1 -> chk_done pulse, par_err=0, err_cnt=0.
- RX bad frame: same frame with parity bit 0 -> par_err and chk_done coincide, err_sticky=1, err_cnt=1. Then 255 further bad frames -> err_cnt stays at 8'hFF.
- RX restart and no-parity:
  - frame_start after 4 bits, then a full good frame -> exactly one chk_done, no error.
  - par_en=0 -> chk_done one cycle after the 8th bit; an extra bit_valid in IDLE is ignored.
- err_clr coincident with par_err -> err_sticky=1, err_cnt=1.
- With PARITY_STATS_EN undefined -> err_cnt stays 0 throughout.
